uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (legal 5..9).
REQ-002 Parameter OVERSAMPLE, default 16, baud_clk cycles per bit (even, legal 8..32).
REQ-003 Parameter PARITY_MODE, default 0, parity: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked (legal 1 or 2).
REQ-005 baud_clk  input  1  sampling clock at OVERSAMPLE x baud rate; the only clock, rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 serial_in  input  1  serial line, idle high, LSB-first frames.
REQ-008 rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-009 rx_data  output  DATA_BITS  received byte held in holding register.
REQ-010 rx_valid  output  1  holding register full.
REQ-011 parity_err, framing_err  output  1 each  status of the frame in rx_data, valid with rx_valid.
REQ-012 overrun_err  output  1  sticky: a frame completed while holding register full.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states IDLE, START, DATA, PARITY, STOP; a bit counter (0..OVERSAMPLE-1) and a data bit index.
REQ-015 IDLE -> START on the first edge sampling serial_in=0 after a sample of 1 (edge 0); counter cleared at edge 0.
REQ-016 START: at counter OVERSAMPLE/2-1, a bit value of 1 is a false start -> IDLE, no output change; 0 -> DATA, counter cleared.
REQ-017 DATA/PARITY/STOP: each bit is sampled when counter reaches OVERSAMPLE-1, then the counter clears.
REQ-018 DATA shifts in DATA_BITS bits LSB first; then PARITY if PARITY_MODE!=0, else STOP.
REQ-019 PARITY: parity_err computed as XOR of data bits and parity bit, compared against even (1) or odd (2).
REQ-020 STOP: each of STOP_BITS samples must be 1; any 0 sets framing_err for the frame; rest of stop bits still sampled.
REQ-021 On the last stop-bit sample the FSM returns to IDLE the same edge; back-to-back frames with no idle gap are received.
REQ-022 Frame completion with rx_valid=0, or with rx_valid=1 and rx_ready=1 that edge: load rx_data, parity_err, framing_err; rx_valid=1 on the next edge.
REQ-023 Frame completion with rx_valid=1 and rx_ready=0: new frame discarded, holding register unchanged, overrun_err set.
REQ-024 rx_valid clears on the edge where rx_valid=1 and rx_ready=1, unless REQ-022 reloads simultaneously.
REQ-025 overrun_err clears only on reset.
REQ-026 serial_in stuck low after framing error: no new start until a 1 is sampled (REQ-015).

Reset
REQ-027 rst_n low asynchronously forces IDLE, counters 0, rx_data 0, rx_valid 0, parity_err 0, framing_err 0, overrun_err 0, busy 0.
REQ-028 Reset mid-frame abandons the frame; no partial data reaches rx_data; after release the prior-sample register reads 1.

Configuration
REQ-029 Macro UART_RX_MAJORITY_EN defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of serial_in sampled at counter target-2, target-1 and target; same sample edge as without.
REQ-030 Macro UART_RX_MAJORITY_EN undefined: bit value is the single serial_in sample at the target count; no extra sample registers.

Verification (DATA_BITS=8, OVERSAMPLE=16, STOP_BITS=1 unless stated)
REQ-031 PARITY_MODE=0, frame 0xA5, rx_ready=1 -> start check edge 7, data samples edges 23..135, stop edge 151, rx_valid=1 at edge 152, rx_data=0xA5, errors 0.
REQ-032 PARITY_MODE=1, 0x03 sent with parity bit 1 -> parity_err=1; same with parity 0 -> parity_err=0.
REQ-033 Low glitch of 4 cycles on idle line -> start check at edge 7 reads 1, returns to IDLE, rx_valid stays 0.
REQ-034 Stop bit driven 0 for frame 0x5A -> rx_data=0x5A, framing_err=1.
REQ-035 Two back-to-back frames 0x11, 0x22 with rx_ready=0 -> rx_data=0x11, overrun_err=1; raising rx_ready then clears rx_valid.
REQ-036 rst_n pulsed low at edge 60 of a frame -> all outputs 0 immediately; next full frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start/data/parity/stop framing into a one-deep holding register.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit-centre sample.
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 baud_clk,
  input  logic                 rst_n,
  input  logic                 serial_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int              CW            = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0]   CNT_LAST      = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]   CNT_HALF      = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      IDX_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      IDX_STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   prev_q;

  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   perr_hold_q, perr_hold_d;
  logic                   ferr_hold_q, ferr_hold_d;
  logic                   ovr_q, ovr_d;

  logic                   bit_val;
  logic                   start_edge;
  logic                   tick;
  logic                   frame_done;
  logic                   par_xor;

`ifdef UART_RX_MAJORITY_EN
  logic hist_q;

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= prev_q;
    end
  end

  // hist_q, prev_q and serial_in are the samples at target-2, target-1 and target
  assign bit_val = (hist_q & prev_q) | (hist_q & serial_in) | (prev_q & serial_in);
`else
  assign bit_val = serial_in;
`endif

  assign start_edge = (state_q == S_IDLE) && prev_q && !serial_in;
  assign tick       = ((state_q == S_START) && (cnt_q == CNT_HALF)) ||
                      (((state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP)) &&
                       (cnt_q == CNT_LAST));
  assign frame_done = tick && (state_q == S_STOP) && (idx_q == IDX_STOP_LAST);
  assign par_xor    = (^shift_q) ^ bit_val;

  // State register
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_START;
      end
      S_START: begin
        if (tick) state_d = bit_val ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick && (idx_q == IDX_DATA_LAST)) begin
          state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (frame_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame datapath: bit counter, bit index, shift register, per-frame error flags
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (start_edge) begin
        // the start edge itself is count 0, so the register holds 1 after it
        cnt_d  = CW'(1);
        idx_d  = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    if (tick) begin
      idx_d = (state_d != state_q) ? 4'd0 : idx_q + 4'd1;
    end

    if (tick && (state_q == S_DATA)) begin
      shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
    end

    if (tick && (state_q == S_PARITY)) begin
      perr_d = (PARITY_MODE == 2) ? ~par_xor : par_xor;
    end

    if (tick && (state_q == S_STOP)) begin
      ferr_d = ferr_q | ~bit_val;
    end
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      prev_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      prev_q  <= serial_in;
    end
  end

  // Holding register: a frame finishing while the previous one is unconsumed is dropped
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    perr_hold_d = perr_hold_q;
    ferr_hold_d = ferr_hold_q;
    ovr_d       = ovr_q;

    if (frame_done && (!rx_valid_q || rx_ready)) begin
      rx_data_d   = shift_q;
      perr_hold_d = perr_q;
      ferr_hold_d = ferr_q | ~bit_val;
      rx_valid_d  = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d  = 1'b0;
    end

    if (frame_done && rx_valid_q && !rx_ready) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      perr_hold_q <= 1'b0;
      ferr_hold_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      perr_hold_q <= perr_hold_d;
      ferr_hold_q <= ferr_hold_d;
      ovr_q       <= ovr_d;
    end
  end

  // Output logic
  always_comb begin
    busy        = (state_q != S_IDLE);
    rx_data     = rx_data_q;
    rx_valid    = rx_valid_q;
    parity_err  = perr_hold_q;
    framing_err = ferr_hold_q;
    overrun_err = ovr_q;
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: framing timing, parity, glitch, framing error, overrun, reset.
module tb_uart_rx_core;
  localparam int OS = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rdy   = 1'b1;
  logic       line  = 1'b1;
  logic       sel   = 1'b0;
  logic       ser0, ser1;

  logic [7:0] d0, d1;
  logic       v0, pe0, fe0, ov0, b0;
  logic       v1, pe1, fe1, ov1, b1;

  logic [7:0] m_data;
  logic       m_valid, m_pe, m_fe, m_ov, m_busy;

  int edge_cnt  = 0;
  int start_ref = 0;
  int n_checks  = 0;
  int n_errors  = 0;

  int         busy_rel, valid_rel, cnt;
  logic [7:0] cap_data;
  logic       cap_pe, cap_fe, cap_ov;

  assign ser0 = sel ? 1'b1 : line;
  assign ser1 = sel ? line : 1'b1;

  assign m_data  = sel ? d1  : d0;
  assign m_valid = sel ? v1  : v0;
  assign m_pe    = sel ? pe1 : pe0;
  assign m_fe    = sel ? fe1 : fe0;
  assign m_ov    = sel ? ov1 : ov0;
  assign m_busy  = sel ? b1  : b0;

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(1)) u_dut (
    .baud_clk(clk), .rst_n(rst_n), .serial_in(ser0), .rx_ready(rdy),
    .rx_data(d0), .rx_valid(v0), .parity_err(pe0), .framing_err(fe0),
    .overrun_err(ov0), .busy(b0)
  );

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(1)) u_dut_par (
    .baud_clk(clk), .rst_n(rst_n), .serial_in(ser1), .rx_ready(rdy),
    .rx_data(d1), .rx_valid(v1), .parity_err(pe1), .framing_err(fe1),
    .overrun_err(ov1), .busy(b1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; holds the line for one bit period
  task automatic drive_bit(input logic b);
    line = b;
    repeat (OS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_en,
                            input logic par_bit, input logic stop_val);
    start_ref = edge_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (par_en) drive_bit(par_bit);
    drive_bit(stop_val);
    line = 1'b1;
  endtask

  // Records first busy and first rx_valid, as edges after the start edge
  task automatic monitor(input int limit, output int b_rel, output int v_rel,
                         output logic [7:0] data, output logic pe, output logic fe,
                         output logic ov);
    b_rel = -1; v_rel = -1; data = '0; pe = 1'b0; fe = 1'b0; ov = 1'b0;
    for (int n = 0; n < limit && v_rel < 0; n++) begin
      @(negedge clk);
      if (m_busy && b_rel < 0) b_rel = edge_cnt - start_ref;
      if (m_valid) begin
        v_rel = edge_cnt - start_ref;
        data  = m_data;
        pe    = m_pe;
        fe    = m_fe;
        ov    = m_ov;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench timed out");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset rx_valid", 32'(v0), 32'd0);
    check("reset rx_data", 32'(d0), 32'd0);
    check("reset busy", 32'(b0), 32'd0);
    check("reset parity_err", 32'(pe0), 32'd0);
    check("reset framing_err", 32'(fe0), 32'd0);
    check("reset overrun_err", 32'(ov0), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Plain frame 0xA5: busy after edge 0, stop sampled at edge 151
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      monitor(300, busy_rel, valid_rel, cap_data, cap_pe, cap_fe, cap_ov);
    join
    check("A5 busy rel", 32'(busy_rel), 32'd1);
    check("A5 valid rel", 32'(valid_rel), 32'd152);
    check("A5 data", 32'(cap_data), 32'hA5);
    check("A5 parity_err", 32'(cap_pe), 32'd0);
    check("A5 framing_err", 32'(cap_fe), 32'd0);
    check("A5 overrun", 32'(cap_ov), 32'd0);
    check("A5 valid consumed", 32'(v0), 32'd0);
    check("A5 idle busy", 32'(b0), 32'd0);

    // Even parity: 0x03 has two ones, so parity bit 1 is wrong and 0 is right
    sel = 1'b1;
    fork
      send_frame(8'h03, 1'b1, 1'b1, 1'b1);
      monitor(300, busy_rel, valid_rel, cap_data, cap_pe, cap_fe, cap_ov);
    join
    check("par1 data", 32'(cap_data), 32'h03);
    check("par1 parity_err", 32'(cap_pe), 32'd1);
    check("par1 framing_err", 32'(cap_fe), 32'd0);
    fork
      send_frame(8'h03, 1'b1, 1'b0, 1'b1);
      monitor(300, busy_rel, valid_rel, cap_data, cap_pe, cap_fe, cap_ov);
    join
    check("par0 data", 32'(cap_data), 32'h03);
    check("par0 parity_err", 32'(cap_pe), 32'd0);
    sel = 1'b0;
    repeat (4) @(negedge clk);

    // 4-cycle low glitch: false start detected at edge 7
    start_ref = edge_cnt;
    line = 1'b0;
    repeat (4) @(negedge clk);
    line = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch busy before check", 32'(b0), 32'd1);
    @(negedge clk);
    check("glitch busy after check", 32'(b0), 32'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (v0) cnt++;
    end
    check("glitch no valid", 32'(cnt), 32'd0);

    // Stop bit 0: data kept, framing error flagged
    fork
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      monitor(300, busy_rel, valid_rel, cap_data, cap_pe, cap_fe, cap_ov);
    join
    check("5A data", 32'(cap_data), 32'h5A);
    check("5A framing_err", 32'(cap_fe), 32'd1);
    check("5A parity_err", 32'(cap_pe), 32'd0);
    repeat (4) @(negedge clk);

    // Line held low past the frame: no restart until a 1 is seen
    fork
      begin
        start_ref = edge_cnt;
        repeat (13) drive_bit(1'b0);
        line = 1'b1;
      end
      begin
        monitor(300, busy_rel, valid_rel, cap_data, cap_pe, cap_fe, cap_ov);
        cnt = 0;
        repeat (40) begin
          @(negedge clk);
          if (b0) cnt++;
        end
      end
    join
    check("break data", 32'(cap_data), 32'h00);
    check("break framing_err", 32'(cap_fe), 32'd1);
    check("break no restart", 32'(cnt), 32'd0);
    repeat (4) @(negedge clk);

    // Back-to-back frames with consumer stalled: second frame overruns
    rdy = 1'b0;
    fork
      begin
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      end
      monitor(300, busy_rel, valid_rel, cap_data, cap_pe, cap_fe, cap_ov);
    join
    check("b2b first data", 32'(cap_data), 32'h11);
    check("b2b first overrun", 32'(cap_ov), 32'd0);
    check("b2b held data", 32'(d0), 32'h11);
    check("b2b valid held", 32'(v0), 32'd1);
    check("b2b overrun", 32'(ov0), 32'd1);
    rdy = 1'b1;
    @(negedge clk);
    check("b2b valid cleared", 32'(v0), 32'd0);
    check("b2b overrun sticky", 32'(ov0), 32'd1);
    repeat (4) @(negedge clk);

    // Reset at edge 60 of a partial 0x3C frame
    start_ref = edge_cnt;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    line = 1'b1;
    repeat (12) @(negedge clk);
    check("rst busy before", 32'(b0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst busy", 32'(b0), 32'd0);
    check("rst rx_data", 32'(d0), 32'd0);
    check("rst rx_valid", 32'(v0), 32'd0);
    check("rst overrun", 32'(ov0), 32'd0);
    check("rst framing_err", 32'(fe0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (v0 || b0) cnt++;
    end
    check("rst quiet after", 32'(cnt), 32'd0);
    fork
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      monitor(300, busy_rel, valid_rel, cap_data, cap_pe, cap_fe, cap_ov);
    join
    check("3C valid rel", 32'(valid_rel), 32'd152);
    check("3C data", 32'(cap_data), 32'h3C);
    check("3C framing_err", 32'(cap_fe), 32'd0);
    check("3C overrun", 32'(cap_ov), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
